// File: rtl/lcd_cmd_seq.sv
// Command sequencer between a host command source and the LCD image controller.
// Queues host commands, waits out controller boot, strobes each command once and watches for done.
module lcd_cmd_seq #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in_cmd,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       seq_done,
  output logic       err_timeout,
  output logic [7:0] issued_cnt
);

  localparam logic [2:0] CMD_WRITE = 3'd0;

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_GAP,
    S_WAIT_DONE,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t      state_reg, state_next;
  logic        boot_ok_reg, boot_ok_next;
  logic [7:0]  tmo_reg, tmo_next;
  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic        closed_reg, closed_next;
  logic        in_ready_reg, in_ready_next;
  logic [2:0]  cmd_reg, cmd_next;
  logic        cmd_valid_reg, cmd_valid_next;
  logic [7:0]  issued_reg, issued_next;

  logic        push, pop;
  logic        empty, full, full_next;
  logic [2:0]  head;
  logic [2:0]  entry_q [DEPTH];

  // Storage: one register per slot, written only when the write pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [2:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          entry_reg <= in_cmd;
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  assign head  = entry_q[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // in_ready is a register, so a push is never gated by the same-cycle pop.
  assign push = in_valid && in_ready_reg;

  assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
  assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
  assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                       (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  assign closed_next = closed_reg || (push && (in_cmd == CMD_WRITE));

  assign in_ready_next = !full_next && !closed_next &&
                         (state_next != S_FINISH) && (state_next != S_ERROR);

  always_comb begin
    state_next     = state_reg;
    boot_ok_next   = boot_ok_reg;
    tmo_next       = tmo_reg;
    pop            = 1'b0;
    cmd_next       = CMD_WRITE;
    cmd_valid_next = 1'b0;
    issued_next    = issued_reg;

    case (state_reg)
      S_BOOT: begin
        // Two consecutive idle samples skip the controller's own start-up cycle.
        if (lcd_busy) begin
          boot_ok_next = 1'b0;
        end else if (boot_ok_reg) begin
          state_next = S_RUN;
        end else begin
          boot_ok_next = 1'b1;
        end
      end

      S_RUN: begin
        if (!empty && !lcd_busy) begin
          cmd_valid_next = 1'b1;
          cmd_next       = head;
          pop            = 1'b1;
          tmo_next       = 8'd0;
          if (issued_reg != 8'hFF) begin
            issued_next = issued_reg + 8'd1;
          end
          state_next = (head == CMD_WRITE) ? S_WAIT_DONE : S_GAP;
        end
      end

      S_GAP: begin
        state_next = S_RUN;
      end

      S_WAIT_DONE: begin
        tmo_next = tmo_reg + 8'd1;
        // done takes priority over a timeout landing on the same cycle
        if (lcd_done) begin
          state_next = S_FINISH;
        end else if (tmo_next == 8'(TIMEOUT)) begin
          state_next = S_ERROR;
        end
      end

      S_FINISH: state_next = S_FINISH;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_BOOT;
      boot_ok_reg   <= 1'b0;
      tmo_reg       <= 8'd0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      closed_reg    <= 1'b0;
      in_ready_reg  <= 1'b0;
      cmd_reg       <= 3'd0;
      cmd_valid_reg <= 1'b0;
      issued_reg    <= 8'd0;
    end else begin
      state_reg     <= state_next;
      boot_ok_reg   <= boot_ok_next;
      tmo_reg       <= tmo_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      closed_reg    <= closed_next;
      in_ready_reg  <= in_ready_next;
      cmd_reg       <= cmd_next;
      cmd_valid_reg <= cmd_valid_next;
      issued_reg    <= issued_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign cmd         = cmd_reg;
  assign cmd_valid   = cmd_valid_reg;
  assign issued_cnt  = issued_reg;
  assign seq_done    = (state_reg == S_FINISH);
  assign err_timeout = (state_reg == S_ERROR);

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer that sits between the host command source and the LCD image controller (cmd/cmd_valid/busy/done interface).
- Buffers host commands in a small FIFO and waits out the controller's image-load phase.
- Issues each command as a single-cycle cmd_valid pulse only while the controller is not busy.
- Treats the Write command (3'd0) as the terminating command: after issuing it, waits for done, with a watchdog on that wait.

Parameters:
- DEPTH, 8, command FIFO depth in entries; power of two, at least 2.
- AW, 3, FIFO pointer width; equals log2(DEPTH).
- TIMEOUT, 255, maximum cycles in WAIT_DONE before the error state; 8-bit counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_cmd  input  3  host command code (0 Write, 1 Up, 2 Down, 3 Left, 4 Right, 5 Average, 6 MirrorX, 7 MirrorY).
- in_valid  input  1  host offers in_cmd.
- in_ready  output  1  sequencer accepts; a transfer occurs when in_valid and in_ready are both high on a clock edge.
- lcd_busy  input  1  controller busy flag.
- lcd_done  input  1  controller done flag.
- cmd  output  3  command to the controller.
- cmd_valid  output  1  command strobe to the controller.
- seq_done  output  1  sequence complete; sticky.
- err_timeout  output  1  done never arrived; sticky.
- issued_cnt  output  8  number of commands issued; saturates at 255.

Behaviour:
- Reset (asynchronous): state=BOOT, FIFO emptied, closed flag cleared, timeout counter=0. All outputs are 0: in_ready=0, cmd=3'd0, cmd_valid=0, seq_done=0, err_timeout=0, issued_cnt=0.
- Idle value of cmd is 3'd0 whenever cmd_valid=0. The controller acts on Write only when it is qualified by cmd_valid.
- in_ready = !full && !closed && state not in {FINISH, ERROR}. It is combinational from registers; it does not depend on in_valid.
- closed is set on the cycle a Write is accepted into the FIFO. All later host commands are refused until reset.
- A push and a pop in the same cycle are both performed. When full, push is refused even if a pop happens that cycle.
- A command pushed into an empty FIFO can pop no earlier than the next cycle.
- Pointers wrap modulo DEPTH. The FIFO uses an extra wrap bit for full/empty.
- States:
  - BOOT: wait for lcd_busy=0, sampled on 2 consecutive cycles (filters the controller's reset/INITIAL cycle), then go to RUN.
  - RUN: if FIFO not empty and lcd_busy=0, set cmd_valid=1 and cmd=head for exactly 1 cycle, then pop and increment issued_cnt.
    - If the issued command is 0, go to WAIT_DONE.
    - Otherwise go to GAP.
    - If the FIFO is empty, stay in RUN with cmd_valid=0.
  - GAP: 1 cycle, cmd_valid=0, then RUN. This guarantees at least 1 idle cycle between strobes. Minimum issue interval is 2 cycles.
  - WAIT_DONE: cmd_valid=0; the timeout counter increments every cycle.
    - lcd_done=1 goes to FINISH.
    - Otherwise, when the counter reaches TIMEOUT, go to ERROR.
    - If lcd_done arrives on the same cycle the counter reaches TIMEOUT, done wins.
  - FINISH: seq_done=1, terminal; only reset exits.
  - ERROR: err_timeout=1, terminal; only reset exits.
- lcd_done seen in any state other than WAIT_DONE is ignored.
- lcd_busy rising in RUN before a strobe blocks issue. A strobe already driven completes its single cycle.
- Reset asserted mid-sequence discards all queued commands immediately. The next sequence starts in BOOT.

Test Plan:
- Boot gating: lcd_busy=1 for 66 cycles then 0, with Up/Left/Write preloaded. Expect no cmd_valid before lcd_busy has been 0 for 2 cycles. Then strobes cmd=1, 3, 0 at 2-cycle spacing, issued_cnt=3, and seq_done=1 one cycle after lcd_done.
- FIFO full: push 8 non-Write commands while lcd_busy=1. Expect in_ready=0 after the 8th. On release, all 8 issue in order with wrap-around, then in_ready=1 again.
- Close on Write: push 5, 0, 6. Expect 6 refused (in_ready=0 from the cycle after the 0 is accepted). Strobes are 5 then 0 only.
- Timeout: issue Write and hold lcd_done=0. Expect err_timeout=1 after 255 WAIT_DONE cycles, seq_done stays 0, no further strobes.
- Done/timeout tie: lcd_done=1 on the cycle the counter hits 255. Expect seq_done=1 and err_timeout=0.
- Reset mid-run: assert reset with 4 commands queued. Expect all outputs 0 asynchronously and no stale command issued after reset deasserts.
